// File: rtl/game_state_tap.sv
// game_state_tap
//
// Shadows the processor's register-file writes to the game-status registers
// (level, screen, end-of-game) and commits them to the display outputs only
// when the VGA timing signals a frame boundary. The renderer therefore never
// sees a value change in the middle of a frame.
//
// Ports:
//   clock            master clock, shared with the processor
//   reset            synchronous, active-high reset
//   ctrl_writeEnable regfile write enable from the processor
//   ctrl_writeReg    regfile write index from the processor
//   data_writeReg    regfile write data from the processor
//   frame_start      one-cycle pulse at the start of vertical blank
//   level            committed level (low 8 bits of the level register)
//   screen           committed screen (low 8 bits of the screen register)
//   game_over        committed end-of-game flag, sticky until reset
//   update_pulse     high for the single cycle in which a commit lands
//   pending          shadow holds changes still waiting for a frame boundary
//   commit_count     saturating count of commits since reset
module game_state_tap #(
    parameter int LEVEL_REG  = 3,
    parameter int SCREEN_REG = 4,
    parameter int END_REG    = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_writeEnable,
    input  logic [4:0]  ctrl_writeReg,
    input  logic [31:0] data_writeReg,
    input  logic        frame_start,
    output logic [7:0]  level,
    output logic [7:0]  screen,
    output logic        game_over,
    output logic        update_pulse,
    output logic        pending,
    output logic [15:0] commit_count
);

    localparam logic [4:0] LEVEL_IDX  = 5'(LEVEL_REG);
    localparam logic [4:0] SCREEN_IDX = 5'(SCREEN_REG);
    localparam logic [4:0] END_IDX    = 5'(END_REG);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        FROZEN
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0] shadow_level;
    logic [7:0] shadow_screen;
    logic       shadow_end;

    logic hit_level;
    logic hit_screen;
    logic hit_end;
    logic write_end_value;
    logic dirty;
    logic commit;

    // Decode which shadow register (if any) this cycle's write targets and
    // whether it actually changes the shadow. Register 0 is hard-wired in the
    // processor, so a write to it never counts even if a parameter names it.
    always_comb begin
        hit_level       = 1'b0;
        hit_screen      = 1'b0;
        hit_end         = 1'b0;
        write_end_value = (data_writeReg != 32'd0);
        if (ctrl_writeEnable && (ctrl_writeReg != 5'd0)) begin
            hit_level  = (ctrl_writeReg == LEVEL_IDX);
            hit_screen = (ctrl_writeReg == SCREEN_IDX);
            hit_end    = (ctrl_writeReg == END_IDX);
        end
        dirty = (hit_level  && (data_writeReg[7:0] != shadow_level))  ||
                (hit_screen && (data_writeReg[7:0] != shadow_screen)) ||
                (hit_end    && (write_end_value    != shadow_end));
        commit = (state == PENDING) && frame_start;
    end

    // Next-state logic. A commit out of PENDING freezes the block once the
    // committed end-of-game flag is set; otherwise a dirty write arriving in
    // the commit cycle keeps us pending so it is published next frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dirty) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    if (shadow_end) begin
                        state_next = FROZEN;
                    end else if (dirty) begin
                        state_next = PENDING;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            FROZEN: begin
                state_next = FROZEN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shadow registers follow every matching write, including while frozen,
    // so they always mirror what the program last wrote.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_level  <= 8'd0;
            shadow_screen <= 8'd0;
            shadow_end    <= 1'b0;
        end else begin
            if (hit_level) begin
                shadow_level <= data_writeReg[7:0];
            end
            if (hit_screen) begin
                shadow_screen <= data_writeReg[7:0];
            end
            if (hit_end) begin
                shadow_end <= write_end_value;
            end
        end
    end

    // State register and committed outputs. A commit copies the shadows as
    // they stood before this cycle's write, which is what the registers still
    // hold at this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            level        <= 8'd0;
            screen       <= 8'd0;
            game_over    <= 1'b0;
            update_pulse <= 1'b0;
            commit_count <= 16'd0;
        end else begin
            state        <= state_next;
            update_pulse <= commit;
            if (commit) begin
                level     <= shadow_level;
                screen    <= shadow_screen;
                game_over <= shadow_end;
                if (commit_count != 16'hFFFF) begin
                    commit_count <= commit_count + 16'd1;
                end
            end
        end
    end

    // Decoded straight from the state register, so it is still a registered
    // output with no path from any input.
    assign pending = (state == PENDING);

endmodule

// File: tb/tb_game_state_tap.sv
// tb_game_state_tap
//
// Directed bench for game_state_tap. Each vector drives the write port and
// frame_start for one clock, then the outputs are compared against values
// worked out by hand from the intended behaviour.
module tb_game_state_tap;

    logic        clock;
    logic        reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        frame_start;
    logic [7:0]  level;
    logic [7:0]  screen;
    logic        game_over;
    logic        update_pulse;
    logic        pending;
    logic [15:0] commit_count;

    int assertCount;
    int failCount;

    game_state_tap #(
        .LEVEL_REG (3),
        .SCREEN_REG(4),
        .END_REG   (6)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg   (ctrl_writeReg),
        .data_writeReg   (data_writeReg),
        .frame_start     (frame_start),
        .level           (level),
        .screen          (screen),
        .game_over       (game_over),
        .update_pulse    (update_pulse),
        .pending         (pending),
        .commit_count    (commit_count)
    );

    // 100 MHz style free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one cycle of write-port and frame_start activity, let the rising
    // edge sample it, then settle 1 time unit past the edge so the outputs
    // can be read safely.
    task automatic applyStimulus(input logic we, input logic [4:0] idx,
                                 input logic [31:0] data, input logic fs);
        ctrl_writeEnable = we;
        ctrl_writeReg    = idx;
        data_writeReg    = data;
        frame_start      = fs;
        @(posedge clock);
        #1;
    endtask

    // Compare one observed value to its expected value, counting every
    // comparison and reporting any disagreement.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Check all committed outputs at once against expected values.
    task automatic checkAll(input string tag, input logic [7:0] expLevel,
                            input logic [7:0] expScreen, input logic expOver,
                            input logic expPulse, input logic expPending,
                            input logic [15:0] expCount);
        checkOutput({tag, ".level"},   32'(level),        32'(expLevel));
        checkOutput({tag, ".screen"},  32'(screen),       32'(expScreen));
        checkOutput({tag, ".over"},    32'(game_over),    32'(expOver));
        checkOutput({tag, ".pulse"},   32'(update_pulse), 32'(expPulse));
        checkOutput({tag, ".pending"}, 32'(pending),      32'(expPending));
        checkOutput({tag, ".count"},   32'(commit_count), 32'(expCount));
    endtask

    // Main directed sequence.
    initial begin
        assertCount      = 0;
        failCount        = 0;
        reset            = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        frame_start      = 1'b0;
        #1;

        // Reset with random write traffic must leave everything cleared.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 5'($urandom_range(0, 7)), $urandom, 1'($urandom));
        end
        checkAll("reset", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkAll("idle_fs", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Basic commit: level and screen written, published at frame_start.
        applyStimulus(1'b1, 5'd3, 32'h0000_0102, 1'b0);
        checkOutput("basic.pending_rise", 32'(pending), 32'd1);
        applyStimulus(1'b1, 5'd4, 32'h0000_0005, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        end
        checkAll("basic.wait", 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 16'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkAll("basic.commit", 8'h02, 8'h05, 1'b0, 1'b1, 1'b0, 16'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("basic.pulse_end", 32'(update_pulse), 32'd0);

        // Filtering: other registers, register 0, disabled writes and an
        // identical rewrite must not mark anything dirty.
        applyStimulus(1'b1, 5'd5, 32'd7, 1'b0);
        applyStimulus(1'b1, 5'd0, 32'd9, 1'b0);
        applyStimulus(1'b0, 5'd3, 32'd77, 1'b0);
        applyStimulus(1'b1, 5'd3, 32'h0000_0002, 1'b0);
        checkOutput("filter.pending", 32'(pending), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkAll("filter.fs", 8'h02, 8'h05, 1'b0, 1'b0, 1'b0, 16'd1);

        // Simultaneous write and frame_start: old shadow is committed, the
        // new value waits for the following frame.
        applyStimulus(1'b1, 5'd4, 32'd3, 1'b0);
        checkOutput("simul.pending", 32'(pending), 32'd1);
        applyStimulus(1'b1, 5'd4, 32'd8, 1'b1);
        checkAll("simul.first", 8'h02, 8'h03, 1'b0, 1'b1, 1'b1, 16'd2);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkAll("simul.second", 8'h02, 8'h08, 1'b0, 1'b1, 1'b0, 16'd3);

        // Game over freezes the display until reset.
        applyStimulus(1'b1, 5'd6, 32'd1, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkAll("over.commit", 8'h02, 8'h08, 1'b1, 1'b1, 1'b0, 16'd4);
        applyStimulus(1'b1, 5'd3, 32'd9, 1'b0);
        checkOutput("over.no_pending", 32'(pending), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
            checkAll("over.frozen", 8'h02, 8'h08, 1'b1, 1'b0, 1'b0, 16'd4);
        end
        reset = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        reset = 1'b0;
        checkAll("over.reset", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Saturation: a dirty write in every frame_start cycle keeps the
        // block pending, so every cycle commits.
        applyStimulus(1'b1, 5'd3, 32'd1, 1'b0);
        for (int i = 0; i < 65534; i++) begin
            applyStimulus(1'b1, 5'd3, (i % 2 == 0) ? 32'd2 : 32'd1, 1'b1);
        end
        checkOutput("sat.almost", 32'(commit_count), 32'h0000_FFFE);
        applyStimulus(1'b1, 5'd3, 32'd2, 1'b1);
        checkOutput("sat.full", 32'(commit_count), 32'h0000_FFFF);
        checkOutput("sat.pulse", 32'(update_pulse), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd3, (i % 2 == 0) ? 32'd1 : 32'd2, 1'b1);
        end
        checkOutput("sat.hold", 32'(commit_count), 32'h0000_FFFF);
        checkOutput("sat.still_pending", 32'(pending), 32'd1);

        // Reset while pending drops the pending commit entirely.
        reset = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
        reset = 1'b0;
        checkAll("midreset", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
        checkAll("midreset.fs", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
